// File: rtl/sensor_tx_pkg.sv
// Shared types and constants for the sensor-to-UART arbiter.
package sensor_tx_pkg;

  localparam int N_SENSORS = 8;
  localparam int WORD_W    = 16;
  localparam int ID_W      = 3;

  localparam int HI_MSB = 15;
  localparam int HI_LSB = 8;
  localparam int LO_MSB = 7;
  localparam int LO_LSB = 0;

  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND_HI = 3'd1,
    S_WAIT_HI = 3'd2,
    S_SEND_LO = 3'd3,
    S_WAIT_LO = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Single-cycle round-robin search: first set req bit after 'last', wrapping mod 8.
module rr_picker
  import sensor_tx_pkg::*;
(
  input  logic [N_SENSORS-1:0] req,
  input  logic [ID_W-1:0]      last,
  output logic                 hit,
  output logic [ID_W-1:0]      id
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is the final winner.
  always_comb begin
    hit = 1'b0;
    id  = '0;
    idx = '0;
    for (int off = N_SENSORS; off >= 1; off--) begin
      idx = last + ID_W'(off);
      if (req[idx]) begin
        hit = 1'b1;
        id  = idx;
      end
    end
  end

endmodule

// File: rtl/sensor_tx_arbiter.sv
// Round-robin arbiter that latches one sensor frame and sends it to the UART as two bytes.
module sensor_tx_arbiter
  import sensor_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SENSORS-1:0]        sensor_ready,
  input  logic [N_SENSORS*WORD_W-1:0] sensor_bus,
  output logic [N_SENSORS-1:0]        data_used,
  output logic [7:0]                  tx_byte,
  output logic                        tx_start,
  input  logic                        tx_busy,
  input  logic                        tx_done,
  output logic [ID_W-1:0]             grant_id,
  output logic                        active,
  output logic                        timeout_err,
  output logic [7:0]                  err_count
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_MAX) ? v : v + 8'd1;
  endfunction

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [7:0]          err_q, err_d;
  logic                terr_q, terr_d;

  logic                pick_hit;
  logic [ID_W-1:0]     pick_id;
  logic                wd_hit;
  logic [WORD_W-1:0]   frames [N_SENSORS];

  always_comb begin
    for (int i = 0; i < N_SENSORS; i++) begin
      frames[i] = sensor_bus[i*WORD_W +: WORD_W];
    end
  end

  rr_picker u_picker (
    .req  (sensor_ready),
    .last (last_q),
    .hit  (pick_hit),
    .id   (pick_id)
  );

  assign wd_hit = (wd_q == WD_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // tx_done has priority over the watchdog limit in both wait states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pick_hit) state_d = S_SEND_HI;
      S_SEND_HI: if (!tx_busy) state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tx_done)     state_d = S_SEND_LO;
        else if (wd_hit) state_d = S_RELEASE;
      end
      S_SEND_LO: if (!tx_busy) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (tx_done || wd_hit) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d  = last_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    wd_d    = wd_q;
    err_d   = err_q;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_hit) begin
          hold_d  = frames[pick_id];
          grant_d = pick_id;
        end
      end
      S_SEND_HI, S_SEND_LO: wd_d = '0;
      S_WAIT_HI, S_WAIT_LO: begin
        if (!tx_done) begin
          if (wd_hit) begin
            terr_d = 1'b1;
            err_d  = sat_inc(err_q);
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      S_RELEASE: last_d = grant_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= ID_W'(N_SENSORS - 1);
      grant_q <= '0;
      hold_q  <= '0;
      wd_q    <= '0;
      err_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    tx_start  = 1'b0;
    tx_byte   = '0;
    data_used = '0;
    case (state_q)
      S_SEND_HI: begin
        tx_start = !tx_busy;
        tx_byte  = hold_q[HI_MSB:HI_LSB];
      end
      S_WAIT_HI: tx_byte = hold_q[HI_MSB:HI_LSB];
      S_SEND_LO: begin
        tx_start = !tx_busy;
        tx_byte  = hold_q[LO_MSB:LO_LSB];
      end
      S_WAIT_LO: tx_byte = hold_q[LO_MSB:LO_LSB];
      S_RELEASE: data_used[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign active      = (state_q != S_IDLE);
  assign grant_id    = grant_q;
  assign err_count   = err_q;
  assign timeout_err = terr_q;

endmodule
